// File: rtl/rate_seq_pkg.sv
// Shared types and the speed-to-reload mapping for the rate sequencer.
package rate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SPD_FAST = 2'b00,
    SPD_X1   = 2'b01,
    SPD_X2   = 2'b10,
    SPD_X4   = 2'b11
  } speed_t;

  localparam int unsigned FN_W = 64;

  // Reload is period minus one; callers narrow the result to their counter width.
  function automatic logic [FN_W-1:0] period_reload(input speed_t speed,
                                                    input logic [FN_W-1:0] base);
    logic [FN_W-1:0] reload;
    case (speed)
      SPD_FAST: reload = 64'd0;
      SPD_X1:   reload = base - 64'd1;
      SPD_X2:   reload = (base << 1) - 64'd1;
      SPD_X4:   reload = (base << 2) - 64'd1;
      default:  reload = 64'd0;
    endcase
    return reload;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable, holdable down-counter with a terminal-count flag; never wraps below zero.
module tick_timer #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: load beats hold; a zero count sits until reloaded.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (hold || zero) begin
      cnt_r <= cnt_r;
    end else begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/rate_sequencer.sv
// Run/pause/step/clear sequencer producing the display counter enable at a selectable rate.
// Optional macro WRAP_PAUSE_EN: auto-pause after 16 run ticks, resume on a run rising edge.
module rate_sequencer
  import rate_seq_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 50000000,
  parameter int unsigned CNT_W       = 28
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [1:0] speed_sel,
  input  logic       run,
  input  logic       step_req,
  input  logic       clear_req,
  output logic       tick,
  output logic       count_clr,
  output logic [1:0] state_o,
  output logic [1:0] speed_active,
  output logic       wrap_done
);

  state_t           state_r, state_s;
  logic             tick_r, tick_s;
  logic             clr_r, clr_s;
  logic [1:0]       speed_active_r, speed_s;
  logic             load_s, hold_s, timer_zero_s, resume_ok_s;
  logic [CNT_W-1:0] reload_s, load_val_s;

`ifdef WRAP_PAUSE_EN
  logic [3:0] tally_r, tally_s;
  logic       wait_low_r, wait_low_s;
  logic       wrap_done_r, wrap_s;

  // After an auto-pause, run must be seen low before a resume is accepted.
  assign resume_ok_s = !wait_low_r;
  assign wrap_done   = wrap_done_r;
`else
  assign resume_ok_s = 1'b1;
  assign wrap_done   = 1'b0;
`endif

  assign reload_s = CNT_W'(period_reload(speed_t'(speed_sel), 64'(BASE_PERIOD)));

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (CLOCK_50),
    .resetn   (resetn),
    .load     (load_s),
    .load_val (load_val_s),
    .hold     (hold_s),
    .zero     (timer_zero_s)
  );

  // Next-state, timer control and next output values; clear outranks every other request.
  always_comb begin
    state_s    = state_r;
    tick_s     = 1'b0;
    clr_s      = 1'b0;
    speed_s    = speed_active_r;
    load_s     = 1'b0;
    hold_s     = 1'b1;
    load_val_s = reload_s;
`ifdef WRAP_PAUSE_EN
    tally_s    = tally_r;
    wait_low_s = wait_low_r;
    wrap_s     = 1'b0;
`endif
    if (clear_req) begin
      clr_s      = 1'b1;
      state_s    = ST_IDLE;
      load_s     = 1'b1;
      load_val_s = {CNT_W{1'b0}};
`ifdef WRAP_PAUSE_EN
      tally_s    = 4'd0;
      wait_low_s = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run) begin
            state_s = ST_RUN;
            load_s  = 1'b1;
            speed_s = speed_sel;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state_s = ST_PAUSE;
          end else if (timer_zero_s) begin
            tick_s  = 1'b1;
            load_s  = 1'b1;
            speed_s = speed_sel;
`ifdef WRAP_PAUSE_EN
            tally_s = tally_r + 4'd1;
            if (tally_r == 4'd15) begin
              state_s    = ST_PAUSE;
              wrap_s     = 1'b1;
              wait_low_s = 1'b1;
            end else begin
              state_s = ST_RUN;
            end
`endif
          end else begin
            hold_s = 1'b0;
          end
        end
        ST_PAUSE: begin
`ifdef WRAP_PAUSE_EN
          if (!run) begin
            wait_low_s = 1'b0;
          end else begin
            wait_low_s = wait_low_r;
          end
`endif
          if (run && resume_ok_s) begin
            state_s = ST_RUN;
          end else if (!run && step_req) begin
            tick_s = 1'b1;
          end else begin
            state_s = ST_PAUSE;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          load_s     = 1'b1;
          load_val_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Registered state and outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      tick_r         <= 1'b0;
      clr_r          <= 1'b0;
      speed_active_r <= 2'b00;
`ifdef WRAP_PAUSE_EN
      tally_r        <= 4'd0;
      wait_low_r     <= 1'b0;
      wrap_done_r    <= 1'b0;
`endif
    end else begin
      state_r        <= state_s;
      tick_r         <= tick_s;
      clr_r          <= clr_s;
      speed_active_r <= speed_s;
`ifdef WRAP_PAUSE_EN
      tally_r        <= tally_s;
      wait_low_r     <= wait_low_s;
      wrap_done_r    <= wrap_s;
`endif
    end
  end

  assign tick         = tick_r;
  assign count_clr    = clr_r;
  assign state_o      = state_r;
  assign speed_active = speed_active_r;

endmodule
